// File: rtl/cmlb_sa_pkg.sv
// Shared types and constants for the set-associative code MLB (cmlb_sa).
// The payload width and global-bit position are fixed package constants.
package cmlb_sa_pkg;

  localparam int CMLB_DATA_W     = 32;
  localparam int CMLB_GLOBAL_BIT = 31;

  localparam int CMLB_WAYS    = 8;
  localparam int CMLB_SETS    = 64;
  localparam int CMLB_IP_W    = 65;
  localparam int CMLB_ASID_W  = 21;
  localparam int CMLB_PAGE_SH = 14;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    MISS  = 2'd2,
    FLUSH = 2'd3
  } cmlb_state_e;

  typedef struct packed {
    logic                                valid;
    logic [CMLB_IP_W-CMLB_PAGE_SH-1:0]   tag;
    logic [CMLB_ASID_W-1:0]              asid;
    logic [CMLB_DATA_W-1:0]              data;
  } cmlb_entry_t;

  // Age field width for a given associativity (never below one bit).
  function automatic int cmlb_age_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cmlb_sa_if.sv
// Fetch / page-walker / maintenance port bundle of cmlb_sa.
// CMLB_SA_PERF_EN adds the saturating performance counter outputs.
interface cmlb_sa_if
  import cmlb_sa_pkg::*;
#(
  parameter int IP_W   = CMLB_IP_W,
  parameter int ASID_W = CMLB_ASID_W,
  parameter int DATA_W = CMLB_DATA_W
);
  logic              read_clkEn;
  logic              fStall;
  logic [IP_W-1:0]   addr;
  logic [ASID_W-1:0] asid;
  logic              read_hit;
  logic              read_miss;
  logic [DATA_W-1:0] read_data;
  logic              busy;
  logic              miss_req;
  logic [IP_W-1:0]   miss_addr;
  logic              miss_ack;
  logic              miss_fault;
  logic [DATA_W-1:0] fill_data;
  logic              inv_en;
  logic [IP_W-1:0]   inv_addr;
  logic              flush;
  logic              flush_done;
`ifdef CMLB_SA_PERF_EN
  logic [31:0]       perf_hits;
  logic [31:0]       perf_misses;
  logic [31:0]       perf_faults;

  modport master (
    output read_clkEn, fStall, addr, asid, miss_ack, miss_fault, fill_data,
           inv_en, inv_addr, flush,
    input  read_hit, read_miss, read_data, busy, miss_req, miss_addr, flush_done,
           perf_hits, perf_misses, perf_faults
  );
  modport slave (
    input  read_clkEn, fStall, addr, asid, miss_ack, miss_fault, fill_data,
           inv_en, inv_addr, flush,
    output read_hit, read_miss, read_data, busy, miss_req, miss_addr, flush_done,
           perf_hits, perf_misses, perf_faults
  );
`else
  modport master (
    output read_clkEn, fStall, addr, asid, miss_ack, miss_fault, fill_data,
           inv_en, inv_addr, flush,
    input  read_hit, read_miss, read_data, busy, miss_req, miss_addr, flush_done
  );
  modport slave (
    input  read_clkEn, fStall, addr, asid, miss_ack, miss_fault, fill_data,
           inv_en, inv_addr, flush,
    output read_hit, read_miss, read_data, busy, miss_req, miss_addr, flush_done
  );
`endif
endinterface

// File: rtl/cmlb_sa_chk.sv
// Run-time checks for cmlb_sa: a lookup may match at most one way.
module cmlb_sa_chk #(
  parameter int WAYS = 8
) (
  input logic            clk,
  input logic            rst,
  input logic            acc,
  input logic [WAYS-1:0] way_hit
);
  // At most one way may hit an accepted lookup
  always @(posedge clk) begin
    if (rst && acc) begin
      assert ($onehot0(way_hit)) else $error("cmlb_sa multi-hit %b", way_hit);
    end
  end
endmodule

// File: rtl/cmlb_sa_lru.sv
// Per-set age-based LRU: promotion of one way and victim selection.
// Ages form a permutation of 0..WAYS-1; age 0 is the least recently used.
module cmlb_sa_lru
  import cmlb_sa_pkg::*;
#(
  parameter int WAYS = CMLB_WAYS,
  parameter int AW   = cmlb_age_w(CMLB_WAYS)
) (
  input  logic [WAYS-1:0]         valid,
  input  logic [WAYS-1:0][AW-1:0] ages,
  input  logic [AW-1:0]           upd_way,
  output logic [WAYS-1:0][AW-1:0] ages_nxt,
  output logic [AW-1:0]           victim
);
  logic [AW-1:0] inv_pick_s;
  logic [AW-1:0] old_pick_s;
  logic [AW-1:0] old_age_s;

  // Victim: lowest-index invalid way, otherwise the way whose age is zero
  always_comb begin
    inv_pick_s = {AW{1'b0}};
    old_pick_s = {AW{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      inv_pick_s = valid[w] ? inv_pick_s : AW'(w);
      old_pick_s = (ages[w] == {AW{1'b0}}) ? AW'(w) : old_pick_s;
    end
    victim = (&valid) ? old_pick_s : inv_pick_s;
  end

  // Promote upd_way to youngest; ways younger than its old age move down one
  always_comb begin
    old_age_s = ages[upd_way];
    for (int w = 0; w < WAYS; w++) begin
      if (AW'(w) == upd_way) begin
        ages_nxt[w] = AW'(WAYS - 1);
      end else if (ages[w] > old_age_s) begin
        ages_nxt[w] = ages[w] - AW'(1);
      end else begin
        ages_nxt[w] = ages[w];
      end
    end
  end
endmodule

// File: rtl/cmlb_sa.sv
// cmlb_sa: parametrised set-associative code MLB with registered lookup,
// page-walker miss handshake with in-place fill, per-address invalidate,
// full flush and ASID/global matching.
// Optional: CMLB_SA_PERF_EN adds perf_hits/perf_misses/perf_faults.
module cmlb_sa
  import cmlb_sa_pkg::*;
#(
  parameter int WAYS    = CMLB_WAYS,
  parameter int SETS    = CMLB_SETS,
  parameter int IP_W    = CMLB_IP_W,
  parameter int ASID_W  = CMLB_ASID_W,
  parameter int DATA_W  = CMLB_DATA_W,
  parameter int GBIT    = CMLB_GLOBAL_BIT,
  parameter int PAGE_SH = CMLB_PAGE_SH
) (
  input logic      clk,
  input logic      rst,
  cmlb_sa_if.slave bus
);
  localparam int AW    = cmlb_age_w(WAYS);
  localparam int SW    = $clog2(SETS);
  localparam int TAG_W = IP_W - PAGE_SH;

  // Entry array (valid is swept on INIT/FLUSH, so no reset is needed)
  logic [WAYS-1:0]             valid_r [SETS];
  logic [WAYS-1:0][TAG_W-1:0]  tag_r   [SETS];
  logic [WAYS-1:0][ASID_W-1:0] asid_r  [SETS];
  logic [WAYS-1:0][DATA_W-1:0] data_r  [SETS];
  logic [WAYS-1:0][AW-1:0]     age_r   [SETS];

  cmlb_state_e       state_r;
  logic [SW-1:0]     sweep_r;
  logic              busy_r, miss_req_r, flush_pend_r, flush_done_r;
  logic [IP_W-1:0]   miss_addr_r;
  logic [ASID_W-1:0] miss_asid_r;
  logic              read_hit_r, read_miss_r;
  logic [DATA_W-1:0] read_data_r;

  logic [SW-1:0]     lk_set_s, inv_set_s, miss_set_s, lru_set_s, wr_set_s;
  logic [TAG_W-1:0]  lk_tag_s, inv_tag_s, miss_tag_s;
  logic [WAYS-1:0]   way_hit_s, inv_match_s, clr_mask_s;
  logic [AW-1:0]     hit_way_s, victim_s, upd_way_s, fill_way_s;
  logic [DATA_W-1:0] hit_data_s;
  logic [WAYS-1:0][AW-1:0] ages_nxt_s;
  logic acc_s, inv_act_s, inv_kill_s, lk_hit_s, lk_miss_s;
  logic flush_any_s, fill_s, fault_s, fill_en_s, age_upd_s;

  assign lk_set_s   = bus.addr[PAGE_SH +: SW];
  assign lk_tag_s   = bus.addr[IP_W-1:PAGE_SH];
  assign inv_set_s  = bus.inv_addr[PAGE_SH +: SW];
  assign inv_tag_s  = bus.inv_addr[IP_W-1:PAGE_SH];
  assign miss_set_s = miss_addr_r[PAGE_SH +: SW];
  assign miss_tag_s = miss_addr_r[IP_W-1:PAGE_SH];

  // A lookup coinciding with a flush request is dropped; fetch sees busy next
  assign acc_s       = (state_r == RUN) && bus.read_clkEn && !bus.fStall && !bus.flush;
  assign inv_act_s   = (state_r == RUN) && bus.inv_en && !bus.flush;
  assign inv_kill_s  = inv_act_s && (inv_set_s == lk_set_s);
  assign lk_hit_s    = acc_s && (|way_hit_s) && !inv_kill_s;
  assign lk_miss_s   = acc_s && !lk_hit_s;
  assign flush_any_s = flush_pend_r || bus.flush;
  assign fill_s      = (state_r == MISS) && bus.miss_ack && !bus.miss_fault && !flush_any_s;
  assign fault_s     = (state_r == MISS) && bus.miss_ack && bus.miss_fault && !flush_any_s;

  // Way compare for the lookup set and the invalidate set
  always_comb begin
    way_hit_s   = {WAYS{1'b0}};
    inv_match_s = {WAYS{1'b0}};
    hit_way_s   = {AW{1'b0}};
    hit_data_s  = {DATA_W{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      way_hit_s[w] = valid_r[lk_set_s][w] && (tag_r[lk_set_s][w] == lk_tag_s) &&
                     ((asid_r[lk_set_s][w] == bus.asid) || data_r[lk_set_s][w][GBIT]);
      inv_match_s[w] = valid_r[inv_set_s][w] && (tag_r[inv_set_s][w] == inv_tag_s) &&
                       ((asid_r[inv_set_s][w] == bus.asid) || data_r[inv_set_s][w][GBIT]);
      hit_way_s  = way_hit_s[w] ? AW'(w) : hit_way_s;
      hit_data_s = hit_data_s | (way_hit_s[w] ? data_r[lk_set_s][w] : {DATA_W{1'b0}});
    end
  end

  assign lru_set_s = (state_r == MISS) ? miss_set_s : lk_set_s;
  assign upd_way_s = (state_r == MISS) ? victim_s : hit_way_s;
  assign age_upd_s = lk_hit_s || fill_s;

  cmlb_sa_lru #(.WAYS(WAYS), .AW(AW)) u_lru (
    .valid    (valid_r[lru_set_s]),
    .ages     (age_r[lru_set_s]),
    .upd_way  (upd_way_s),
    .ages_nxt (ages_nxt_s),
    .victim   (victim_s)
  );

  // Single entry write port: sweep, invalidate or fill depending on state
  always_comb begin
    wr_set_s   = {SW{1'b0}};
    clr_mask_s = {WAYS{1'b0}};
    fill_en_s  = 1'b0;
    fill_way_s = {AW{1'b0}};
    case (state_r)
      INIT, FLUSH: begin
        wr_set_s   = sweep_r;
        clr_mask_s = {WAYS{1'b1}};
      end
      RUN: begin
        wr_set_s   = inv_set_s;
        clr_mask_s = inv_act_s ? inv_match_s : {WAYS{1'b0}};
      end
      MISS: begin
        wr_set_s   = miss_set_s;
        fill_en_s  = fill_s;
        fill_way_s = victim_s;
      end
      default: begin
        wr_set_s = {SW{1'b0}};
      end
    endcase
  end

  // Entry array update
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (fill_en_s && (fill_way_s == AW'(w))) begin
        valid_r[wr_set_s][w] <= 1'b1;
        tag_r[wr_set_s][w]   <= miss_tag_s;
        asid_r[wr_set_s][w]  <= miss_asid_r;
        data_r[wr_set_s][w]  <= bus.fill_data;
      end else if (clr_mask_s[w]) begin
        valid_r[wr_set_s][w] <= 1'b0;
      end
    end
  end

  // Age array: reload way index during INIT, promote on hit or fill
  always_ff @(posedge clk) begin
    if (state_r == INIT) begin
      for (int w = 0; w < WAYS; w++) begin
        age_r[sweep_r][w] <= AW'(w);
      end
    end else if (age_upd_s) begin
      age_r[lru_set_s] <= ages_nxt_s;
    end
  end

  // Control FSM: init sweep, lookup, walker handshake, flush sweep
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= INIT;
      sweep_r      <= {SW{1'b0}};
      busy_r       <= 1'b1;
      miss_req_r   <= 1'b0;
      miss_addr_r  <= {IP_W{1'b0}};
      miss_asid_r  <= {ASID_W{1'b0}};
      flush_pend_r <= 1'b0;
      flush_done_r <= 1'b0;
    end else begin
      flush_done_r <= 1'b0;
      case (state_r)
        INIT: begin
          sweep_r <= sweep_r + SW'(1);
          if (sweep_r == SW'(SETS - 1)) begin
            state_r <= RUN;
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_r <= FLUSH;
            busy_r  <= 1'b1;
            sweep_r <= {SW{1'b0}};
          end else if (lk_miss_s) begin
            state_r     <= MISS;
            busy_r      <= 1'b1;
            miss_req_r  <= 1'b1;
            miss_addr_r <= bus.addr;
            miss_asid_r <= bus.asid;
          end
        end
        MISS: begin
          if (bus.flush) begin
            flush_pend_r <= 1'b1;
          end
          if (bus.miss_ack) begin
            miss_req_r <= 1'b0;
            if (flush_any_s) begin
              state_r      <= FLUSH;
              sweep_r      <= {SW{1'b0}};
              flush_pend_r <= 1'b0;
            end else begin
              state_r <= RUN;
              busy_r  <= 1'b0;
            end
          end
        end
        FLUSH: begin
          sweep_r <= sweep_r + SW'(1);
          if (sweep_r == SW'(SETS - 1)) begin
            state_r      <= RUN;
            busy_r       <= 1'b0;
            flush_done_r <= 1'b1;
          end
        end
        default: begin
          state_r <= INIT;
          sweep_r <= {SW{1'b0}};
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Registered lookup result; held under fStall, a walker fault re-reports miss
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_hit_r  <= 1'b0;
      read_miss_r <= 1'b0;
      read_data_r <= {DATA_W{1'b0}};
    end else if (fault_s) begin
      read_hit_r  <= 1'b0;
      read_miss_r <= 1'b1;
      read_data_r <= {DATA_W{1'b0}};
    end else if (bus.fStall) begin
      read_hit_r  <= read_hit_r;
      read_miss_r <= read_miss_r;
      read_data_r <= read_data_r;
    end else begin
      read_hit_r  <= lk_hit_s;
      read_miss_r <= lk_miss_s;
      read_data_r <= lk_hit_s ? hit_data_s : {DATA_W{1'b0}};
    end
  end

  assign bus.read_hit   = read_hit_r;
  assign bus.read_miss  = read_miss_r;
  assign bus.read_data  = read_data_r;
  assign bus.busy       = busy_r;
  assign bus.miss_req   = miss_req_r;
  assign bus.miss_addr  = miss_addr_r;
  assign bus.flush_done = flush_done_r;

`ifdef CMLB_SA_PERF_EN
  logic [31:0] perf_hits_r, perf_misses_r, perf_faults_r;
  logic        perf_clr_s;

  assign perf_clr_s = bus.flush && ((state_r == RUN) || (state_r == MISS));

  // Saturating event counters, cleared by reset and by an accepted flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_hits_r   <= 32'd0;
      perf_misses_r <= 32'd0;
      perf_faults_r <= 32'd0;
    end else if (perf_clr_s) begin
      perf_hits_r   <= 32'd0;
      perf_misses_r <= 32'd0;
      perf_faults_r <= 32'd0;
    end else begin
      if (lk_hit_s && (perf_hits_r != 32'hFFFF_FFFF)) begin
        perf_hits_r <= perf_hits_r + 32'd1;
      end
      if (lk_miss_s && (perf_misses_r != 32'hFFFF_FFFF)) begin
        perf_misses_r <= perf_misses_r + 32'd1;
      end
      if (fault_s && (perf_faults_r != 32'hFFFF_FFFF)) begin
        perf_faults_r <= perf_faults_r + 32'd1;
      end
    end
  end

  assign bus.perf_hits   = perf_hits_r;
  assign bus.perf_misses = perf_misses_r;
  assign bus.perf_faults = perf_faults_r;
`endif

  cmlb_sa_chk #(.WAYS(WAYS)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .acc     (acc_s),
    .way_hit (way_hit_s)
  );
endmodule

// File: tb/tb_cmlb_sa.sv
// Directed self-checking bench for cmlb_sa (default WAYS=8, SETS=64).
module tb_cmlb_sa;
  import cmlb_sa_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmlb_sa_if bus_if ();
  cmlb_sa dut (.clk(clk), .rst(rst), .bus(bus_if));

  int n_checks = 0;
  int n_fail   = 0;
  logic [CMLB_DATA_W-1:0] gdata;

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [64:0] a, input logic [20:0] s);
    bus_if.addr       = a;
    bus_if.asid       = s;
    bus_if.read_clkEn = 1'b1;
    tick();
    bus_if.read_clkEn = 1'b0;
  endtask

  task automatic do_ack(input logic [CMLB_DATA_W-1:0] d, input logic f);
    bus_if.miss_ack   = 1'b1;
    bus_if.miss_fault = f;
    bus_if.fill_data  = d;
    tick();
    bus_if.miss_ack   = 1'b0;
    bus_if.miss_fault = 1'b0;
  endtask

  task automatic miss_fill(input string tag, input logic [64:0] a, input logic [20:0] s,
                           input logic [CMLB_DATA_W-1:0] d);
    do_lookup(a, s);
    check_eq({tag, "_miss"}, 65'(bus_if.read_miss), 65'd1);
    do_ack(d, 1'b0);
    check_eq({tag, "_req_drop"}, 65'(bus_if.miss_req), 65'd0);
  endtask

  task automatic wait_busy_low(input string tag);
    int cnt;
    cnt = 0;
    while (bus_if.busy && (cnt < 200)) begin
      tick();
      cnt++;
    end
    check_eq(tag, 65'(cnt), 65'd64);
  endtask

  initial begin
    rst               = 1'b0;
    bus_if.read_clkEn = 1'b0;
    bus_if.fStall     = 1'b0;
    bus_if.addr       = 65'd0;
    bus_if.asid       = 21'd0;
    bus_if.miss_ack   = 1'b0;
    bus_if.miss_fault = 1'b0;
    bus_if.fill_data  = '0;
    bus_if.inv_en     = 1'b0;
    bus_if.inv_addr   = 65'd0;
    bus_if.flush      = 1'b0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_busy", 65'(bus_if.busy), 65'd1);
    check_eq("rst_hit", 65'(bus_if.read_hit), 65'd0);
    check_eq("rst_miss", 65'(bus_if.read_miss), 65'd0);
    check_eq("rst_req", 65'(bus_if.miss_req), 65'd0);
    check_eq("rst_fdone", 65'(bus_if.flush_done), 65'd0);
    rst = 1'b1;
    wait_busy_low("init_cycles");

    // First miss, walker slow to answer, then fill and replay
    do_lookup(65'h4000, 21'd1);
    check_eq("m1_miss", 65'(bus_if.read_miss), 65'd1);
    check_eq("m1_hit", 65'(bus_if.read_hit), 65'd0);
    check_eq("m1_req", 65'(bus_if.miss_req), 65'd1);
    check_eq("m1_addr", bus_if.miss_addr, 65'h4000);
    check_eq("m1_busy", 65'(bus_if.busy), 65'd1);
    repeat (3) tick();
    check_eq("m1_pulse", 65'(bus_if.read_miss), 65'd0);
    check_eq("m1_req_hold", 65'(bus_if.miss_req), 65'd1);
    do_ack(32'h55, 1'b0);
    check_eq("m1_req_drop", 65'(bus_if.miss_req), 65'd0);
    check_eq("m1_busy_drop", 65'(bus_if.busy), 65'd0);
    do_lookup(65'h4000, 21'd1);
    check_eq("m1_replay_hit", 65'(bus_if.read_hit), 65'd1);
    check_eq("m1_replay_data", 65'(bus_if.read_data), 65'h55);

    // fStall freezes the result registers and blocks new lookups
    bus_if.fStall     = 1'b1;
    bus_if.read_clkEn = 1'b1;
    bus_if.addr       = 65'h1234_0000;
    tick();
    check_eq("stall_hit", 65'(bus_if.read_hit), 65'd1);
    check_eq("stall_data", 65'(bus_if.read_data), 65'h55);
    check_eq("stall_busy", 65'(bus_if.busy), 65'd0);
    bus_if.fStall     = 1'b0;
    bus_if.read_clkEn = 1'b0;
    tick();
    check_eq("idle_hit", 65'(bus_if.read_hit), 65'd0);

    // Nine tags into set 0: the first one filled is the LRU victim
    for (int k = 1; k <= 9; k++) begin
      miss_fill("set0_fill", 65'(k) << 20, 21'd1, CMLB_DATA_W'(k));
    end
    for (int k = 2; k <= 9; k++) begin
      do_lookup(65'(k) << 20, 21'd1);
      check_eq("set0_hit", 65'(bus_if.read_hit), 65'd1);
      check_eq("set0_data", 65'(bus_if.read_data), 65'(k));
    end
    do_lookup(65'd1 << 20, 21'd1);
    check_eq("set0_evicted", 65'(bus_if.read_miss), 65'd1);

    // Walker fault: no fill, miss re-reported, replay misses again
    do_ack(32'h0, 1'b1);
    check_eq("fault_miss", 65'(bus_if.read_miss), 65'd1);
    check_eq("fault_data", 65'(bus_if.read_data), 65'd0);
    check_eq("fault_req", 65'(bus_if.miss_req), 65'd0);
`ifdef CMLB_SA_PERF_EN
    check_eq("perf_faults", 65'(bus_if.perf_faults), 65'd1);
`endif
    miss_fill("fault_replay", 65'd1 << 20, 21'd1, 32'h1);

    // Global page matches any ASID; a private page does not
    gdata = '0;
    gdata[CMLB_GLOBAL_BIT] = 1'b1;
    gdata[7:0] = 8'h77;
    miss_fill("glob_fill", 65'h8000, 21'd3, gdata);
    do_lookup(65'h8000, 21'd7);
    check_eq("glob_hit", 65'(bus_if.read_hit), 65'd1);
    check_eq("glob_data", 65'(bus_if.read_data), 65'(gdata));
    miss_fill("priv_fill", 65'hC000, 21'd3, 32'h66);
    miss_fill("priv_other_asid", 65'hC000, 21'd7, 32'h67);

    // Invalidate by address, and invalidate winning over a same-set lookup
    bus_if.inv_en   = 1'b1;
    bus_if.inv_addr = 65'h4000;
    bus_if.asid     = 21'd1;
    tick();
    bus_if.inv_en   = 1'b0;
    miss_fill("inv_gone", 65'h4000, 21'd1, 32'h55);
    bus_if.inv_en   = 1'b1;
    do_lookup(65'h4000, 21'd1);
    bus_if.inv_en   = 1'b0;
    check_eq("inv_vs_lookup_miss", 65'(bus_if.read_miss), 65'd1);
    check_eq("inv_vs_lookup_hit", 65'(bus_if.read_hit), 65'd0);
    do_ack(32'h56, 1'b0);
    bus_if.inv_en   = 1'b1;
    bus_if.inv_addr = 65'h8000;
    bus_if.asid     = 21'd5;
    tick();
    bus_if.inv_en   = 1'b0;
    miss_fill("inv_global", 65'h8000, 21'd7, 32'h78);

    // Flush during a pending walk: fill dropped, sweep, prior hits miss
    do_lookup(65'h10000, 21'd1);
    check_eq("fl_miss", 65'(bus_if.read_miss), 65'd1);
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    check_eq("fl_req_hold", 65'(bus_if.miss_req), 65'd1);
    do_ack(32'hAA, 1'b0);
    check_eq("fl_req_drop", 65'(bus_if.miss_req), 65'd0);
    check_eq("fl_busy", 65'(bus_if.busy), 65'd1);
    begin
      int cnt;
      cnt = 0;
      while (!bus_if.flush_done && (cnt < 200)) begin
        tick();
        cnt++;
      end
      check_eq("fl_done_cycles", 65'(cnt), 65'd64);
    end
    check_eq("fl_done_busy", 65'(bus_if.busy), 65'd0);
    tick();
    check_eq("fl_done_pulse", 65'(bus_if.flush_done), 65'd0);
    miss_fill("fl_prior_gone", 65'h8000, 21'd7, 32'h79);
    miss_fill("fl_fill_dropped", 65'h10000, 21'd1, 32'hAB);
`ifdef CMLB_SA_PERF_EN
    check_eq("perf_misses_post_flush", 65'(bus_if.perf_misses), 65'd2);
    check_eq("perf_faults_post_flush", 65'(bus_if.perf_faults), 65'd0);
`endif

    // Reset in the middle of a walk abandons it
    do_lookup(65'h14000, 21'd1);
    check_eq("mid_req", 65'(bus_if.miss_req), 65'd1);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_req", 65'(bus_if.miss_req), 65'd0);
    check_eq("mid_rst_busy", 65'(bus_if.busy), 65'd1);
    tick();
    rst = 1'b1;
    wait_busy_low("reinit_cycles");
    do_lookup(65'h10000, 21'd1);
    check_eq("reinit_miss", 65'(bus_if.read_miss), 65'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
